// File: rtl/rv2t_csr_access_ctl.sv
// rv2t_csr_access_ctl
//   Sequencer for RISC-V Zicsr instructions (CSRRW/S/C and immediate forms).
//   A decoded instruction is accepted on a one-cycle start pulse. The block then
//   issues one CSR read, waits for the CSR file's response, and in a single
//   write cycle presents the new CSR value and writes the old value back to rd.
//
// Ports
//   clk, reset_n                 clock, synchronous active-low reset
//   start, funct3, csr_addr,     decoded instruction fields. src is rs1_data for
//   rs1_data, zimm, rd           register forms, zero-extended zimm otherwise
//   flush                        aborts any access in progress
//   csr_read_enable/_addr        one-cycle read strobe to the CSR file
//   csr_read_en_out/_data,       CSR file response: data valid, data,
//   csr_illegal                  illegal-address flag
//   csr_write_enable/_addr/_data CSR write strobe and value
//   rd_write_enable/rd_addr/     register-file writeback of the old CSR value
//   rd_data
//   busy, done, illegal_out      access in progress, completion pulse,
//                                illegal-instruction pulse
module rv2t_csr_access_ctl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [11:0] csr_addr,
    input  logic [31:0] rs1_data,
    input  logic [4:0]  zimm,
    input  logic [4:0]  rd,
    input  logic        flush,
    output logic        csr_read_enable,
    output logic [11:0] csr_read_addr,
    input  logic        csr_read_en_out,
    input  logic [31:0] csr_read_data,
    input  logic        csr_illegal,
    output logic        csr_write_enable,
    output logic [11:0] csr_write_addr,
    output logic [31:0] csr_write_data,
    output logic        rd_write_enable,
    output logic [4:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic        busy,
    output logic        done,
    output logic        illegal_out
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_WRITE = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [1:0]  op_q, op_d;        // funct3[1:0]: 01 write, 10 set, 11 clear
    logic [11:0] addr_q, addr_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] src_q, src_d;
    logic        wreq_q, wreq_d;
    logic [1:0]  tmo_q, tmo_d;
    logic        ren_q, ren_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rwe_q, rwe_d;
    logic [31:0] rdata_q, rdata_d;
    logic        done_q, done_d;
    logic        ill_q, ill_d;
    logic        busy_q, busy_d;

    // Decode of the incoming instruction. Set/clear forms only write when the
    // rs1/zimm field is non-zero; CSRs at 0xC00-0xFFF are read-only.
    logic wreq_in, start_ill;
    assign wreq_in   = (funct3[1:0] == 2'b01) || (zimm != 5'd0);
    assign start_ill = (funct3[1:0] == 2'b00) ||
                       (wreq_in && (csr_addr[11:10] == 2'b11));

    logic [31:0] new_val;
    always_comb begin
        case (op_q)
            2'b10:   new_val = csr_read_data | src_q;
            2'b11:   new_val = csr_read_data & ~src_q;
            default: new_val = src_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        rd_d    = rd_q;
        src_d   = src_q;
        wreq_d  = wreq_q;
        tmo_d   = 2'd0;
        ren_d   = 1'b0;
        we_d    = 1'b0;
        wdata_d = wdata_q;
        rwe_d   = 1'b0;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        ill_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    if (start_ill) begin
                        ill_d = 1'b1;
                    end else begin
                        op_d    = funct3[1:0];
                        addr_d  = csr_addr;
                        rd_d    = rd;
                        src_d   = funct3[2] ? {27'd0, zimm} : rs1_data;
                        wreq_d  = wreq_in;
                        ren_d   = 1'b1;
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                state_d = flush ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (csr_illegal) begin
                    ill_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (csr_read_en_out) begin
                    we_d    = wreq_q;
                    wdata_d = new_val;
                    rwe_d   = (rd_q != 5'd0);
                    rdata_d = csr_read_data;
                    done_d  = 1'b1;
                    state_d = S_WRITE;
                end else if (tmo_q == 2'd3) begin
                    // fourth silent WAIT cycle: give up on the CSR file
                    ill_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 2'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            op_q    <= 2'd0;
            addr_q  <= 12'd0;
            rd_q    <= 5'd0;
            src_q   <= 32'd0;
            wreq_q  <= 1'b0;
            tmo_q   <= 2'd0;
            ren_q   <= 1'b0;
            we_q    <= 1'b0;
            wdata_q <= 32'd0;
            rwe_q   <= 1'b0;
            rdata_q <= 32'd0;
            done_q  <= 1'b0;
            ill_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            src_q   <= src_d;
            wreq_q  <= wreq_d;
            tmo_q   <= tmo_d;
            ren_q   <= ren_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rwe_q   <= rwe_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            ill_q   <= ill_d;
            busy_q  <= busy_d;
        end
    end

    // The strobes are already registered when the cycle they belong to begins,
    // so a flush or reset arriving in that same cycle has to mask them here to
    // cancel the access.
    logic kill;
    assign kill = flush || !reset_n;

    assign csr_read_enable  = ren_q  && !kill;
    assign csr_write_enable = we_q   && !kill;
    assign rd_write_enable  = rwe_q  && !kill;
    assign done             = done_q && !kill;
    assign csr_read_addr    = addr_q;
    assign csr_write_addr   = addr_q;
    assign csr_write_data   = wdata_q;
    assign rd_addr          = rd_q;
    assign rd_data          = rdata_q;
    assign busy             = busy_q;
    assign illegal_out      = ill_q;

endmodule

// File: tb/tb_rv2t_csr_access_ctl.sv
module tb_rv2t_csr_access_ctl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [11:0] csr_addr = 12'd0;
    logic [31:0] rs1_data = 32'd0;
    logic [4:0]  zimm = 5'd0;
    logic [4:0]  rd = 5'd0;
    logic        flush = 1'b0;
    logic        csr_read_enable;
    logic [11:0] csr_read_addr;
    logic        csr_read_en_out = 1'b0;
    logic [31:0] csr_read_data = 32'd0;
    logic        csr_illegal = 1'b0;
    logic        csr_write_enable;
    logic [11:0] csr_write_addr;
    logic [31:0] csr_write_data;
    logic        rd_write_enable;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        busy, done, illegal_out;

    rv2t_csr_access_ctl dut (
        .clk(clk), .reset_n(reset_n), .start(start), .funct3(funct3),
        .csr_addr(csr_addr), .rs1_data(rs1_data), .zimm(zimm), .rd(rd),
        .flush(flush), .csr_read_enable(csr_read_enable),
        .csr_read_addr(csr_read_addr), .csr_read_en_out(csr_read_en_out),
        .csr_read_data(csr_read_data), .csr_illegal(csr_illegal),
        .csr_write_enable(csr_write_enable), .csr_write_addr(csr_write_addr),
        .csr_write_data(csr_write_data), .rd_write_enable(rd_write_enable),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
        .illegal_out(illegal_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        bit          ill;
        bit          we;
        logic [11:0] waddr;
        logic [31:0] wdata;
        bit          rwe;
        logic [4:0]  rd;
        logic [31:0] rdata;
        int          at;
    } exp_t;

    exp_t q[$];

    // CSR file model: answers in the cycle after the read strobe.
    // mode 0 = normal data, 1 = illegal address, 2 = never responds.
    int          mode = 0;
    logic [31:0] csr_val = 32'd0;
    logic [11:0] exp_raddr = 12'd0;
    int          rstrobes = 0;
    bit          pend = 1'b0;
    bit          rsp;

    always @(negedge clk) begin
        if (csr_read_enable === 1'b1) begin
            rstrobes++;
            chk("read_addr", {20'd0, csr_read_addr}, {20'd0, exp_raddr});
        end
        rsp  = pend;
        pend = (csr_read_enable === 1'b1);
        csr_read_en_out = rsp && (mode == 0);
        csr_illegal     = rsp && (mode == 1);
        csr_read_data   = rsp ? csr_val : 32'd0;
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        if (done === 1'b1 || illegal_out === 1'b1 ||
            csr_write_enable === 1'b1 || rd_write_enable === 1'b1) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_event: done=%b ill=%b we=%b rwe=%b, none expected (cycle %0d)",
                         done, illegal_out, csr_write_enable, rd_write_enable, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("event_cycle", cyc, e.at);
                chk("illegal_out", {31'd0, illegal_out}, {31'd0, e.ill});
                chk("done", {31'd0, done}, {31'd0, !e.ill});
                chk("csr_write_enable", {31'd0, csr_write_enable}, {31'd0, e.we});
                if (e.we) begin
                    chk("csr_write_addr", {20'd0, csr_write_addr}, {20'd0, e.waddr});
                    chk("csr_write_data", csr_write_data, e.wdata);
                end
                chk("rd_write_enable", {31'd0, rd_write_enable}, {31'd0, e.rwe});
                if (!e.ill) begin
                    chk("rd_addr", {27'd0, rd_addr}, {27'd0, e.rd});
                    chk("rd_data", rd_data, e.rdata);
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] f, input logic [11:0] a, input logic [31:0] r,
                         input logic [4:0] z, input logic [4:0] d, output int t0);
        @(negedge clk);
        funct3 = f; csr_addr = a; rs1_data = r; zimm = z; rd = d;
        start = 1'b1;
        exp_raddr = a;
        @(posedge clk);
        #1;
        start = 1'b0;
        t0 = cyc;
    endtask

    task automatic push(input bit ill, input bit we, input logic [11:0] wa, input logic [31:0] wd,
                        input bit rwe, input logic [4:0] d, input logic [31:0] rdv, input int at);
        exp_t e;
        e.ill = ill; e.we = we; e.waddr = wa; e.wdata = wd;
        e.rwe = rwe; e.rd = d; e.rdata = rdv; e.at = at;
        q.push_back(e);
    endtask

    initial begin
        repeat (5000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish within 5000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int rs0;

        // reset state
        wait_cyc(2);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_illegal", {31'd0, illegal_out}, 32'd0);
        chk("rst_read_en", {31'd0, csr_read_enable}, 32'd0);
        chk("rst_write_en", {31'd0, csr_write_enable}, 32'd0);
        chk("rst_rd_we", {31'd0, rd_write_enable}, 32'd0);
        chk("rst_wdata", csr_write_data, 32'd0);
        chk("rst_rdata", rd_data, 32'd0);
        chk("rst_raddr", {20'd0, csr_read_addr}, 32'd0);
        reset_n = 1'b1;
        wait_cyc(2);

        // CSRRW 0x340 <- 0xDEADBEEF, old 0x12345678 -> x5; nominal latency
        mode = 0; csr_val = 32'h12345678;
        issue(3'b001, 12'h340, 32'hDEADBEEF, 5'd1, 5'd5, t0);
        push(0, 1, 12'h340, 32'hDEADBEEF, 1, 5'd5, 32'h12345678, t0 + 2);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        wait_cyc(3);
        chk("busy_cleared_cycle4", {31'd0, busy}, 32'd0);

        // CSRRS zimm=0: read only, no CSR write
        csr_val = 32'h88;
        issue(3'b010, 12'h300, 32'hFFFF_FFFF, 5'd0, 5'd3, t0);
        push(0, 0, 12'h300, 32'd0, 1, 5'd3, 32'h88, t0 + 2);
        wait_cyc(4);

        // CSRRCI zimm=8, rd=x0: 0x88 & ~0x08 = 0x80, no rd write
        csr_val = 32'h88;
        issue(3'b111, 12'h304, 32'hFFFF_FFFF, 5'h08, 5'd0, t0);
        push(0, 1, 12'h304, 32'h80, 0, 5'd0, 32'h88, t0 + 2);
        wait_cyc(4);

        // CSRRS register form: 0x00F0 | 0x0F00
        csr_val = 32'h0000_00F0;
        issue(3'b010, 12'h305, 32'h0000_0F00, 5'd1, 5'd7, t0);
        push(0, 1, 12'h305, 32'h0000_0FF0, 1, 5'd7, 32'h0000_00F0, t0 + 2);
        wait_cyc(4);

        // CSRRSI zimm=0x1F: 0x100 | 0x1F, register value ignored
        csr_val = 32'h100;
        issue(3'b110, 12'h306, 32'hAAAA_AAAA, 5'h1F, 5'd1, t0);
        push(0, 1, 12'h306, 32'h11F, 1, 5'd1, 32'h100, t0 + 2);
        wait_cyc(4);

        // CSR file flags illegal address in WAIT
        mode = 1;
        issue(3'b001, 12'h7FF, 32'h1234, 5'd1, 5'd4, t0);
        push(1, 0, 12'h0, 32'd0, 0, 5'd0, 32'd0, t0 + 2);
        wait_cyc(4);
        mode = 0;

        // funct3=100: illegal next cycle, no read strobe
        rs0 = rstrobes;
        issue(3'b100, 12'h340, 32'h1, 5'd1, 5'd2, t0);
        push(1, 0, 12'h0, 32'd0, 0, 5'd0, 32'd0, t0);
        chk("illegal_op_busy", {31'd0, busy}, 32'd0);
        wait_cyc(3);
        chk("illegal_op_no_read", rstrobes, rs0);

        // write to read-only CSR 0xC00 is illegal; a pure read of it is fine
        rs0 = rstrobes;
        issue(3'b001, 12'hC00, 32'h1, 5'd1, 5'd2, t0);
        push(1, 0, 12'h0, 32'd0, 0, 5'd0, 32'd0, t0);
        wait_cyc(3);
        chk("ro_write_no_read", rstrobes, rs0);
        csr_val = 32'h0000_5555;
        issue(3'b011, 12'hC00, 32'hFFFF_FFFF, 5'd0, 5'd9, t0);
        push(0, 0, 12'hC00, 32'd0, 1, 5'd9, 32'h0000_5555, t0 + 2);
        wait_cyc(4);

        // flush in WAIT aborts, even with data arriving
        csr_val = 32'h77;
        issue(3'b001, 12'h341, 32'h99, 5'd1, 5'd6, t0);
        wait_cyc(1);
        flush = 1'b1;
        wait_cyc(1);
        flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_no_write", {31'd0, csr_write_enable}, 32'd0);
        wait_cyc(3);

        // reset asserted in the WRITE cycle suppresses both writes
        issue(3'b001, 12'h342, 32'h55, 5'd1, 5'd8, t0);
        wait_cyc(2);
        reset_n = 1'b0;
        #1;
        chk("rstw_csr_we", {31'd0, csr_write_enable}, 32'd0);
        chk("rstw_rd_we", {31'd0, rd_write_enable}, 32'd0);
        chk("rstw_done", {31'd0, done}, 32'd0);
        wait_cyc(1);
        reset_n = 1'b1;
        chk("rstw_busy", {31'd0, busy}, 32'd0);
        wait_cyc(3);

        // CSR file never answers: illegal after four WAIT cycles
        mode = 2;
        issue(3'b001, 12'h343, 32'h1, 5'd1, 5'd2, t0);
        push(1, 0, 12'h0, 32'd0, 0, 5'd0, 32'd0, t0 + 5);
        wait_cyc(4);
        chk("timeout_busy_in_wait", {31'd0, busy}, 32'd1);
        wait_cyc(4);
        chk("timeout_busy_after", {31'd0, busy}, 32'd0);
        mode = 0;

        // start while busy is ignored
        csr_val = 32'h5;
        issue(3'b001, 12'h344, 32'h1, 5'd1, 5'd2, t0);
        push(0, 1, 12'h344, 32'h1, 1, 5'd2, 32'h5, t0 + 2);
        @(negedge clk);
        funct3 = 3'b001; csr_addr = 12'h345; rs1_data = 32'hF; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_cyc(4);
        chk("busy_start_ignored", {31'd0, busy}, 32'd0);

        // flush outranks start in IDLE
        rs0 = rstrobes;
        @(negedge clk);
        funct3 = 3'b001; csr_addr = 12'h346; start = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        chk("flush_vs_start_busy", {31'd0, busy}, 32'd0);
        wait_cyc(3);
        chk("flush_vs_start_no_read", rstrobes, rs0);

        wait_cyc(3);
        chk("pending_events", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
